bias_pe_array: RTL

Parametrised multi-channel successor to the single bias PE. Holds N_CH bias registers internally instead of taking the bias as a port. Per accepted vector it computes net_sum = bias + sum_in and, in training mode, updates bias <= bias - eta*delta_k. All arithmetic is signed Q(W-FRAC).FRAC with saturation. Sits between the neuron accumulator stage and the activation/backprop stage, with valid/ready handshakes on both sides.

---
 rtl/bias_pe_pkg.sv | 33 +++
 rtl/bias_pe_lane.sv | 74 +++++++
 rtl/bias_pe_array.sv | 78 +++++++
 3 files changed

// File: rtl/bias_pe_pkg.sv
// bias_pe_pkg: shared constants and saturating fixed-point helpers for the bias PE array.
// Contents: default word/fraction widths, W_DEF saturation limits,
// sat_w/sat_add/sat_sub clipping helpers, and fx_mul (product >>> frac, floor).
package bias_pe_pkg;

    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 8;
    localparam logic signed [W_DEF-1:0] SAT_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic signed [W_DEF-1:0] SAT_MIN = {1'b1, {(W_DEF-1){1'b0}}};

    // Operands are carried sign-extended in 64 bits so one helper serves any W <= 32.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return sat_w(a + b, w);
    endfunction

    function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        return sat_w(a - b, w);
    endfunction

    // Full-precision product, arithmetic shift gives floor rounding.
    function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a, input logic signed [63:0] b, input int frac);
        return (a * b) >>> frac;
    endfunction

endpackage

// File: rtl/bias_pe_lane.sv
// bias_pe_lane: one channel of the bias PE array -- bias register, S1 product, S2 arithmetic.
// Ports: clk, rst_n (async active-low); init/init_bias load the bias register;
// s1_load captures sum_in and the delta_k*eta product; s2_load commits the outputs
// and the bias write; tr is the S1 training flag; net_sum/bias_out/sat_flag are registered.
module bias_pe_lane
    import bias_pe_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic [W-1:0] init_bias,
    input  logic         s1_load,
    input  logic         s2_load,
    input  logic         tr,
    input  logic [W-1:0] sum_in,
    input  logic [W-1:0] delta_k,
    input  logic [W-1:0] eta,
    output logic [W-1:0] net_sum,
    output logic [W-1:0] bias_out,
    output logic         sat_flag
);

    logic signed [W-1:0]   bias;
    logic signed [W-1:0]   s1_sum;
    logic signed [2*W-1:0] s1_prod;
    logic signed [2*W-1:0] prod_c;
    logic signed [63:0]    net_raw;
    logic signed [63:0]    net_c;
    logic signed [63:0]    p_c;
    logic signed [63:0]    nb_raw;
    logic signed [63:0]    nb_c;
    logic                  sat_c;

    // Raw (unclipped) values are kept alongside the clipped ones so any clip is detectable.
    always_comb begin
        prod_c  = (2*W)'(fx_mul(64'($signed(delta_k)), 64'($signed(eta)), FRAC));
        net_raw = 64'(bias) + 64'(s1_sum);
        net_c   = sat_add(64'(bias), 64'(s1_sum), W);
        p_c     = sat_w(64'(s1_prod), W);
        nb_raw  = 64'(bias) - p_c;
        nb_c    = tr ? sat_sub(64'(bias), p_c, W) : 64'(bias);
        sat_c   = (net_c != net_raw) || (tr && ((p_c != 64'(s1_prod)) || (nb_c != nb_raw)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias     <= '0;
            s1_sum   <= '0;
            s1_prod  <= '0;
            net_sum  <= '0;
            bias_out <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_sum  <= sum_in;
                s1_prod <= prod_c;
            end
            if (s2_load) begin
                net_sum  <= W'(net_c);
                bias_out <= W'(nb_c);
                sat_flag <= sat_c;
            end
            // init wins over a same-cycle training write; bias_out still reports nb.
            if (init)
                bias <= init_bias;
            else if (s2_load)
                bias <= W'(nb_c);
        end
    end

endmodule

// File: rtl/bias_pe_array.sv
// bias_pe_array: N_CH-lane bias PE with internal bias registers and a 2-stage valid/ready pipeline.
// Ports: ap_clk, ap_rst_n (async active-low), ap_ce (freezes all state when low);
// init_load/init_bias load every bias; in_valid/in_ready with sum_in, delta_k, eta, training;
// out_valid/out_ready with net_sum, bias_out and per-lane sat_flag.
module bias_pe_array
    import bias_pe_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_ce,
    input  logic              init_load,
    input  logic [N_CH*W-1:0] init_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] sum_in,
    input  logic [N_CH*W-1:0] delta_k,
    input  logic [W-1:0]      eta,
    input  logic              training,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] net_sum,
    output logic [N_CH*W-1:0] bias_out,
    output logic [N_CH-1:0]   sat_flag
);

    logic s1_v;
    logic s2_v;
    logic s1_tr;
    logic s1_adv;
    logic s2_adv;
    logic accept;
    logic s2_load;

    assign s2_adv    = !s2_v || out_ready;
    assign s1_adv    = !s1_v || s2_adv;
    assign in_ready  = ap_ce && s1_adv;
    assign accept    = in_valid && in_ready;
    assign s2_load   = ap_ce && s1_v && s2_adv;
    assign out_valid = s2_v;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_v  <= 1'b0;
            s2_v  <= 1'b0;
            s1_tr <= 1'b0;
        end else if (ap_ce) begin
            if (s1_adv) begin
                s1_v  <= in_valid;
                s1_tr <= training;
            end
            if (s2_adv)
                s2_v <= s1_v;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        bias_pe_lane #(.W(W), .FRAC(FRAC)) u_lane (
            .clk      (ap_clk),
            .rst_n    (ap_rst_n),
            .init     (ap_ce && init_load),
            .init_bias(init_bias[i*W +: W]),
            .s1_load  (accept),
            .s2_load  (s2_load),
            .tr       (s1_tr),
            .sum_in   (sum_in[i*W +: W]),
            .delta_k  (delta_k[i*W +: W]),
            .eta      (eta),
            .net_sum  (net_sum[i*W +: W]),
            .bias_out (bias_out[i*W +: W]),
            .sat_flag (sat_flag[i])
        );
    end

endmodule
